// File: rtl/trace_rules_pkg.sv
// Shared constants and helpers for the trace rule register block:
// register offsets, identification constants and the commit state type.
package trace_rules_pkg;

    localparam logic [5:0] REG_NAME             = 6'h00;
    localparam logic [5:0] REG_REV              = 6'h01;
    localparam logic [5:0] REG_RULE_INDEX       = 6'h02;
    localparam logic [5:0] REG_RULE_PATTERN     = 6'h03;
    localparam logic [5:0] REG_RULE_MASK        = 6'h04;
    localparam logic [5:0] REG_RULE_ENABLE      = 6'h05;
    localparam logic [5:0] REG_RULE_TRIG_ENABLE = 6'h06;
    localparam logic [5:0] REG_COMMIT           = 6'h07;
    localparam logic [5:0] REG_RULE_COUNT       = 6'h08;
    localparam logic [5:0] REG_COUNT_CLEAR      = 6'h09;
    localparam logic [5:0] REG_NUM_RULES        = 6'h0A;

    // "RuleTrc" with byte 0 = 'R', byte 7 = NUL
    localparam logic [63:0] TRC_NAME = 64'h0063_7254_656C_7552;
    localparam logic [7:0]  TRC_REV  = 8'h02;

    typedef enum logic [0:0] {
        CMT_IDLE    = 1'b0,
        CMT_PENDING = 1'b1
    } commit_state_e;

    // Byte k of a register that is nbytes wide; bytes past the width read 0.
    function automatic logic [7:0] byte_of(input logic [63:0] v,
                                           input logic [15:0] k,
                                           input logic [3:0]  nbytes);
        logic [7:0] b;
        b = 8'h00;
        for (int j = 0; j < 8; j++) begin
            b = ((k == 16'(j)) && (4'(j) < nbytes)) ? v[j*8 +: 8] : b;
        end
        return b;
    endfunction

endpackage

// File: rtl/reg_trace_rule_counter.sv
// Per-rule saturating match counter with enable and synchronous clear.
module reg_trace_rule_counter
    import trace_rules_pkg::*;
#(
    parameter int unsigned pWIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              inc_i,
    output logic [pWIDTH-1:0] count_o
);

    localparam logic [pWIDTH-1:0] ONE = {{(pWIDTH-1){1'b0}}, 1'b1};

    logic [pWIDTH-1:0] count_q;
    logic [pWIDTH-1:0] count_d;

    // Clear beats increment; holding at all-ones gives saturation.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && inc_i && (count_q != {pWIDTH{1'b1}})) begin
            count_d = count_q + ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Counter state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/reg_trace_rules.sv
// Indexed register window for the trace matcher rules: shadow/active rule
// storage with idle-gated atomic commit, plus per-rule match counters.
module reg_trace_rules
    import trace_rules_pkg::*;
#(
    parameter int unsigned pBYTECNT_SIZE    = 7,
    parameter int unsigned pBUFFER_SIZE     = 64,
    parameter int unsigned pMATCH_RULES     = 16,
    parameter int unsigned pCOUNT_WIDTH     = 32,
    parameter logic [1:0]  pSELECT          = 2'd1,
    parameter int unsigned pREGISTERED_READ = 1
) (
    input  logic                                 usb_clk,
    input  logic                                 reset_n,
    input  logic [7:0]                           reg_address,
    input  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
    input  logic                                 reg_read,
    input  logic                                 reg_write,
    input  logic                                 reg_addrvalid,
    input  logic [7:0]                           write_data,
    output logic [7:0]                           read_data,
    output logic                                 selected,
    input  logic [pMATCH_RULES-1:0]              I_match,
    input  logic                                 I_match_idle,
    output logic [pMATCH_RULES*pBUFFER_SIZE-1:0] O_pattern,
    output logic [pMATCH_RULES*pBUFFER_SIZE-1:0] O_mask,
    output logic [pMATCH_RULES-1:0]              O_enable,
    output logic [pMATCH_RULES-1:0]              O_trig_enable,
    output logic                                 O_rules_updated,
    output logic                                 O_commit_pending
);

    localparam int unsigned BUF_BYTES = pBUFFER_SIZE / 8;
    localparam int unsigned EN_BYTES  = (pMATCH_RULES + 7) / 8;
    localparam int unsigned EN_W      = EN_BYTES * 8;
    localparam int unsigned CNT_BYTES = pCOUNT_WIDTH / 8;
    localparam int unsigned PAT_W     = pMATCH_RULES * pBUFFER_SIZE;

    logic [5:0]  offset_s;
    logic [15:0] bc_s;
    logic        wr_s;
    logic        rd_s;
    logic        pat_we_s;
    logic        mask_we_s;
    logic        en_we_s;
    logic        trig_we_s;
    logic        commit_wr_s;
    logic        clr_s;
    logic        apply_s;

    logic [7:0]       idx_q, idx_d;
    logic [PAT_W-1:0] shadow_pat_q, shadow_pat_d;
    logic [PAT_W-1:0] shadow_mask_q, shadow_mask_d;
    logic [EN_W-1:0]  shadow_en_q, shadow_en_d;
    logic [EN_W-1:0]  shadow_trig_q, shadow_trig_d;
    logic [EN_W-1:0]  en_valid_s;

    logic [PAT_W-1:0]        act_pat_q;
    logic [PAT_W-1:0]        act_mask_q;
    logic [pMATCH_RULES-1:0] act_en_q;
    logic [pMATCH_RULES-1:0] act_trig_q;
    logic                    updated_q;
    commit_state_e           state_q, state_d;

    logic [pMATCH_RULES*pCOUNT_WIDTH-1:0] count_all_s;
    logic [pCOUNT_WIDTH-1:0]              snap_q, snap_d;

    logic [63:0] sel_pat_s;
    logic [63:0] sel_mask_s;
    logic [63:0] live_cnt_s;
    logic [63:0] snap64_s;
    logic [63:0] en64_s;
    logic [63:0] trig64_s;
    logic [7:0]  rd_mux_s;

    assign offset_s    = reg_address[5:0];
    assign bc_s        = 16'(reg_bytecnt);
    assign selected    = reg_addrvalid && (reg_address[7:6] == pSELECT);
    assign wr_s        = selected && reg_write;
    assign rd_s        = selected && reg_read;
    assign pat_we_s    = wr_s && (offset_s == REG_RULE_PATTERN);
    assign mask_we_s   = wr_s && (offset_s == REG_RULE_MASK);
    assign en_we_s     = wr_s && (offset_s == REG_RULE_ENABLE);
    assign trig_we_s   = wr_s && (offset_s == REG_RULE_TRIG_ENABLE);
    assign commit_wr_s = wr_s && (offset_s == REG_COMMIT) && (bc_s == 16'd0);
    assign clr_s       = wr_s && (offset_s == REG_COUNT_CLEAR);

    // Bitmap bits above the rule count stay zero so readback is clean.
    always_comb begin
        en_valid_s                     = '0;
        en_valid_s[pMATCH_RULES-1:0]   = '1;
    end

    // Shadow write decode: only an in-range rule index and byte land.
    always_comb begin
        shadow_pat_d  = shadow_pat_q;
        shadow_mask_d = shadow_mask_q;
        shadow_en_d   = shadow_en_q;
        shadow_trig_d = shadow_trig_q;
        idx_d = (wr_s && (offset_s == REG_RULE_INDEX) && (bc_s == 16'd0)) ? write_data : idx_q;
        for (int i = 0; i < int'(pMATCH_RULES); i++) begin
            for (int k = 0; k < int'(BUF_BYTES); k++) begin
                shadow_pat_d[i*pBUFFER_SIZE + k*8 +: 8] =
                    (pat_we_s && (idx_q == 8'(i)) && (bc_s == 16'(k))) ?
                    write_data : shadow_pat_q[i*pBUFFER_SIZE + k*8 +: 8];
                shadow_mask_d[i*pBUFFER_SIZE + k*8 +: 8] =
                    (mask_we_s && (idx_q == 8'(i)) && (bc_s == 16'(k))) ?
                    write_data : shadow_mask_q[i*pBUFFER_SIZE + k*8 +: 8];
            end
        end
        for (int k = 0; k < int'(EN_BYTES); k++) begin
            shadow_en_d[k*8 +: 8]   = (en_we_s && (bc_s == 16'(k))) ?
                                      write_data : shadow_en_q[k*8 +: 8];
            shadow_trig_d[k*8 +: 8] = (trig_we_s && (bc_s == 16'(k))) ?
                                      write_data : shadow_trig_q[k*8 +: 8];
        end
    end

    // Commit FSM: a cancel beats both a new request and an idle-gated apply.
    always_comb begin
        state_d = state_q;
        apply_s = 1'b0;
        case (state_q)
            CMT_IDLE: begin
                state_d = (commit_wr_s && write_data[0] && !write_data[1]) ?
                          CMT_PENDING : CMT_IDLE;
            end
            CMT_PENDING: begin
                if (commit_wr_s && write_data[1]) begin
                    state_d = CMT_IDLE;
                end else if (I_match_idle) begin
                    apply_s = 1'b1;
                    state_d = (commit_wr_s && write_data[0]) ? CMT_PENDING : CMT_IDLE;
                end else begin
                    state_d = CMT_PENDING;
                end
            end
            default: begin
                state_d = CMT_IDLE;
            end
        endcase
    end

    // Register window, active rule set and commit state.
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q         <= 8'h00;
            shadow_pat_q  <= '0;
            shadow_mask_q <= '1;
            shadow_en_q   <= '0;
            shadow_trig_q <= '0;
            act_pat_q     <= '0;
            act_mask_q    <= '1;
            act_en_q      <= '0;
            act_trig_q    <= '0;
            updated_q     <= 1'b0;
            state_q       <= CMT_IDLE;
            snap_q        <= '0;
        end else begin
            idx_q         <= idx_d;
            shadow_pat_q  <= shadow_pat_d;
            shadow_mask_q <= shadow_mask_d;
            shadow_en_q   <= shadow_en_d & en_valid_s;
            shadow_trig_q <= shadow_trig_d & en_valid_s;
            updated_q     <= apply_s;
            state_q       <= state_d;
            snap_q        <= snap_d;
            if (apply_s) begin
                act_pat_q  <= shadow_pat_q;
                act_mask_q <= shadow_mask_q;
                act_en_q   <= shadow_en_q[pMATCH_RULES-1:0];
                act_trig_q <= shadow_trig_q[pMATCH_RULES-1:0];
            end
        end
    end

    for (genvar g = 0; g < int'(pMATCH_RULES); g++) begin : g_cnt
        reg_trace_rule_counter #(
            .pWIDTH (pCOUNT_WIDTH)
        ) u_cnt (
            .clk_i   (usb_clk),
            .rst_ni  (reset_n),
            .clr_i   (clr_s),
            .en_i    (act_en_q[g]),
            .inc_i   (I_match[g]),
            .count_o (count_all_s[g*pCOUNT_WIDTH +: pCOUNT_WIDTH])
        );
    end

    // Indexed views; an out-of-range index matches no rule and reads zero.
    always_comb begin
        sel_pat_s  = '0;
        sel_mask_s = '0;
        live_cnt_s = '0;
        snap64_s   = '0;
        en64_s     = '0;
        trig64_s   = '0;
        for (int i = 0; i < int'(pMATCH_RULES); i++) begin
            sel_pat_s[pBUFFER_SIZE-1:0]  = (idx_q == 8'(i)) ?
                shadow_pat_q[i*pBUFFER_SIZE +: pBUFFER_SIZE] : sel_pat_s[pBUFFER_SIZE-1:0];
            sel_mask_s[pBUFFER_SIZE-1:0] = (idx_q == 8'(i)) ?
                shadow_mask_q[i*pBUFFER_SIZE +: pBUFFER_SIZE] : sel_mask_s[pBUFFER_SIZE-1:0];
            live_cnt_s[pCOUNT_WIDTH-1:0] = (idx_q == 8'(i)) ?
                count_all_s[i*pCOUNT_WIDTH +: pCOUNT_WIDTH] : live_cnt_s[pCOUNT_WIDTH-1:0];
        end
        snap64_s[pCOUNT_WIDTH-1:0] = snap_q;
        en64_s[EN_W-1:0]           = shadow_en_q;
        trig64_s[EN_W-1:0]         = shadow_trig_q;
    end

    // Byte 0 of RULE_COUNT freezes the whole live value for the upper bytes.
    assign snap_d = (rd_s && (offset_s == REG_RULE_COUNT) && (bc_s == 16'd0)) ?
                    live_cnt_s[pCOUNT_WIDTH-1:0] : snap_q;

    // Read data multiplexer.
    always_comb begin
        rd_mux_s = 8'h00;
        case (offset_s)
            REG_NAME:             rd_mux_s = byte_of(TRC_NAME, bc_s, 4'd8);
            REG_REV:              rd_mux_s = byte_of({56'h0, TRC_REV}, bc_s, 4'd1);
            REG_RULE_INDEX:       rd_mux_s = byte_of({56'h0, idx_q}, bc_s, 4'd1);
            REG_RULE_PATTERN:     rd_mux_s = byte_of(sel_pat_s, bc_s, 4'(BUF_BYTES));
            REG_RULE_MASK:        rd_mux_s = byte_of(sel_mask_s, bc_s, 4'(BUF_BYTES));
            REG_RULE_ENABLE:      rd_mux_s = byte_of(en64_s, bc_s, 4'(EN_BYTES));
            REG_RULE_TRIG_ENABLE: rd_mux_s = byte_of(trig64_s, bc_s, 4'(EN_BYTES));
            REG_COMMIT:           rd_mux_s = byte_of({56'h0, 6'b000000, I_match_idle,
                                                      (state_q == CMT_PENDING)}, bc_s, 4'd1);
            REG_RULE_COUNT:       rd_mux_s = byte_of((bc_s == 16'd0) ? live_cnt_s : snap64_s,
                                                     bc_s, 4'(CNT_BYTES));
            REG_NUM_RULES:        rd_mux_s = byte_of({56'h0, 8'(pMATCH_RULES)}, bc_s, 4'd1);
            default:              rd_mux_s = 8'h00;
        endcase
    end

    if (pREGISTERED_READ != 0) begin : g_rd_reg
        logic [7:0] read_data_q;

        // Registered read port: captures the mux on each read strobe.
        always_ff @(posedge usb_clk or negedge reset_n) begin
            if (!reset_n) begin
                read_data_q <= 8'h00;
            end else if (rd_s) begin
                read_data_q <= rd_mux_s;
            end
        end

        assign read_data = read_data_q;
    end else begin : g_rd_comb
        assign read_data = rd_mux_s;
    end

    assign O_pattern        = act_pat_q;
    assign O_mask           = act_mask_q;
    assign O_enable         = act_en_q;
    assign O_trig_enable    = act_trig_q;
    assign O_rules_updated  = updated_q;
    assign O_commit_pending = (state_q == CMT_PENDING);

endmodule
